// File: rtl/bisr_weight_remap_engine.sv
// BISR weight remap engine: places each logical weight row on a physical row whose
// faulty PEs line up only with zero weights, stores the weights, and serves mapped reads.
module bisr_weight_remap_engine #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ADDR_WIDTH   = $clog2(ROWS),
    parameter int CNT_WIDTH    = $clog2(ROWS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fault_wr_en,
    input  logic [ADDR_WIDTH-1:0]        fault_wr_addr,
    input  logic [COLS-1:0]              fault_wr_pattern,
    input  logic                         cfg_start,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [COLS*WEIGHT_WIDTH-1:0] w_data,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         rd_valid,
    output logic [COLS*WEIGHT_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0]        rd_mapped_addr,
    output logic                         busy,
    output logic                         recovery_done,
    output logic                         recovery_success,
    output logic [CNT_WIDTH-1:0]         unmapped_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic                          w_enter_load;
    logic                          w_accept;
    logic                          w_last;

    logic [COLS-1:0]               r_fault [ROWS];
    logic [ADDR_WIDTH-1:0]         r_map   [ROWS];
    logic [COLS*WEIGHT_WIDTH-1:0]  r_store [ROWS];
    logic [ROWS-1:0]               r_used;
    logic [CNT_WIDTH-1:0]          r_cnt;
    logic                          r_fail;
    logic [CNT_WIDTH-1:0]          r_unmapped;
    logic                          r_rd_valid;
    logic [COLS*WEIGHT_WIDTH-1:0]  r_rd_data;
    logic [ADDR_WIDTH-1:0]         r_rd_map;

    logic [COLS-1:0]               w_zero;
    logic                          w_found_faulty;
    logic                          w_found_clean;
    logic                          w_found_free;
    logic [ADDR_WIDTH-1:0]         w_p_faulty;
    logic [ADDR_WIDTH-1:0]         w_p_clean;
    logic [ADDR_WIDTH-1:0]         w_p_free;
    logic [ADDR_WIDTH-1:0]         w_sel;
    logic                          w_compat;

    assign w_ready  = (r_state == S_LOAD) && !cfg_start;
    assign w_accept = w_valid && w_ready;
    assign w_last   = (r_cnt == CNT_WIDTH'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_enter_load = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (cfg_start) begin
                    w_next       = S_LOAD;
                    w_enter_load = 1'b1;
                end
            end
            S_LOAD: begin
                if (cfg_start) begin
                    w_next       = S_LOAD;
                    w_enter_load = 1'b1;
                end else if (w_accept && w_last) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Faulty-but-compatible rows are taken first so clean rows stay free for dense rows.
    always_comb begin
        w_zero         = '0;
        w_found_faulty = 1'b0;
        w_found_clean  = 1'b0;
        w_found_free   = 1'b0;
        w_p_faulty     = '0;
        w_p_clean      = '0;
        w_p_free       = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            w_zero[c] = (w_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0);
        end
        for (int unsigned p = 0; p < ROWS; p++) begin
            if (!r_used[p]) begin
                if (!w_found_free) begin
                    w_found_free = 1'b1;
                    w_p_free     = ADDR_WIDTH'(p);
                end
                if ((r_fault[p] & ~w_zero) == '0) begin
                    if (r_fault[p] != '0) begin
                        if (!w_found_faulty) begin
                            w_found_faulty = 1'b1;
                            w_p_faulty     = ADDR_WIDTH'(p);
                        end
                    end else if (!w_found_clean) begin
                        w_found_clean = 1'b1;
                        w_p_clean     = ADDR_WIDTH'(p);
                    end
                end
            end
        end
        w_compat = w_found_faulty || w_found_clean;
        if (w_found_faulty)     w_sel = w_p_faulty;
        else if (w_found_clean) w_sel = w_p_clean;
        else                    w_sel = w_p_free;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                r_fault[i] <= '0;
                r_map[i]   <= ADDR_WIDTH'(i);
                r_store[i] <= '0;
            end
            r_used     <= '0;
            r_cnt      <= '0;
            r_fail     <= 1'b0;
            r_unmapped <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_map   <= '0;
        end else begin
            if (fault_wr_en && (r_state == S_IDLE || r_state == S_DONE)) begin
                r_fault[fault_wr_addr] <= fault_wr_pattern;
            end
            if (w_enter_load) begin
                r_used     <= '0;
                r_cnt      <= '0;
                r_fail     <= 1'b0;
                r_unmapped <= '0;
            end else if (w_accept) begin
                r_store[w_sel]                   <= w_data;
                r_map[r_cnt[ADDR_WIDTH-1:0]]     <= w_sel;
                r_used[w_sel]                    <= 1'b1;
                r_cnt                            <= r_cnt + 1'b1;
                if (!w_compat) begin
                    r_fail     <= 1'b1;
                    r_unmapped <= r_unmapped + 1'b1;
                end
            end
            r_rd_valid <= (r_state == S_DONE) && rd_en;
            if ((r_state == S_DONE) && rd_en) begin
                r_rd_map  <= r_map[rd_addr];
                r_rd_data <= r_store[r_map[rd_addr]];
            end
        end
    end

    assign busy             = (r_state == S_LOAD);
    assign recovery_done    = (r_state == S_DONE);
    assign recovery_success = recovery_done && !r_fail;
    assign unmapped_count   = r_unmapped;
    assign rd_valid         = r_rd_valid;
    assign rd_data          = r_rd_data;
    assign rd_mapped_addr   = r_rd_map;

endmodule

// File: tb/tb_bisr_weight_remap_engine.sv
// Directed bench for bisr_weight_remap_engine at ROWS=COLS=4: table-driven allocation
// passes plus hand sequences for stall/restart, LOAD-time side inputs and mid-pass reset.
module tb_bisr_weight_remap_engine;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int WW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fault_wr_en;
    logic [1:0]      fault_wr_addr;
    logic [C-1:0]    fault_wr_pattern;
    logic            cfg_start;
    logic            w_valid;
    logic            w_ready;
    logic [C*WW-1:0] w_data;
    logic            rd_en;
    logic [1:0]      rd_addr;
    logic            rd_valid;
    logic [C*WW-1:0] rd_data;
    logic [1:0]      rd_mapped_addr;
    logic            busy;
    logic            recovery_done;
    logic            recovery_success;
    logic [2:0]      unmapped_count;

    always #5 clk = ~clk;

    bisr_weight_remap_engine #(
        .ROWS(R),
        .COLS(C),
        .WEIGHT_WIDTH(WW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fault_wr_en(fault_wr_en),
        .fault_wr_addr(fault_wr_addr),
        .fault_wr_pattern(fault_wr_pattern),
        .cfg_start(cfg_start),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .w_data(w_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_mapped_addr(rd_mapped_addr),
        .busy(busy),
        .recovery_done(recovery_done),
        .recovery_success(recovery_success),
        .unmapped_count(unmapped_count)
    );

    typedef struct packed {
        logic [3:0][3:0]  flt;
        logic [3:0][31:0] row;
        logic [3:0][1:0]  map;
        logic             succ;
        logic [2:0]       unm;
    } vec_t;

    vec_t vecs [5];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] mkrow(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [15:0] f4(input int a, input int b, input int c, input int d);
        return {d[3:0], c[3:0], b[3:0], a[3:0]};
    endfunction

    function automatic logic [7:0] m4(input int a, input int b, input int c, input int d);
        return {d[1:0], c[1:0], b[1:0], a[1:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic write_faults(input logic [3:0][3:0] f);
        for (int r = 0; r < R; r++) begin
            @(negedge clk);
            fault_wr_en      = 1'b1;
            fault_wr_addr    = 2'(r);
            fault_wr_pattern = f[r];
        end
        @(negedge clk);
        fault_wr_en = 1'b0;
    endtask

    task automatic start_pass();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic feed(input logic [3:0][31:0] rows);
        for (int i = 0; i < R; i++) begin
            @(negedge clk);
            w_valid = 1'b1;
            w_data  = rows[i];
            #1;
            check("w_ready_load", 64'(w_ready), 64'd1);
        end
        @(negedge clk);
        w_valid = 1'b0;
        check("done_after_rows", 64'(recovery_done), 64'd1);
        check("busy_after_rows", 64'(busy), 64'd0);
    endtask

    task automatic read_all(input logic [3:0][1:0] map, input logic [3:0][31:0] rows);
        for (int l = 0; l < R; l++) begin
            @(negedge clk);
            if (l > 0) begin
                check("rd_valid", 64'(rd_valid), 64'd1);
                check("rd_mapped_addr", 64'(rd_mapped_addr), 64'(map[l-1]));
                check("rd_data", 64'(rd_data), 64'(rows[l-1]));
            end
            rd_en   = 1'b1;
            rd_addr = 2'(l);
        end
        @(negedge clk);
        check("rd_valid", 64'(rd_valid), 64'd1);
        check("rd_mapped_addr", 64'(rd_mapped_addr), 64'(map[R-1]));
        check("rd_data", 64'(rd_data), 64'(rows[R-1]));
        rd_en = 1'b0;
        @(negedge clk);
        check("rd_valid_idle", 64'(rd_valid), 64'd0);
    endtask

    initial begin
        logic [3:0][31:0] rows_a;
        logic [3:0][31:0] rows_b;

        // Clean table: identity placement.
        vecs[0].flt    = f4(0, 0, 0, 0);
        vecs[0].row[0] = mkrow(1, 2, 3, 4);
        vecs[0].row[1] = mkrow(5, 6, 7, 8);
        vecs[0].row[2] = mkrow(9, 10, 11, 12);
        vecs[0].row[3] = mkrow(13, 14, 15, 16);
        vecs[0].map    = m4(0, 1, 2, 3);
        vecs[0].succ   = 1'b1;
        vecs[0].unm    = 3'd0;
        // Zero weight lines up with fault: faulty row preferred.
        vecs[1].flt    = f4(0, 0, 'b0010, 0);
        vecs[1].row[0] = mkrow(5, 0, 7, 9);
        vecs[1].row[1] = mkrow('h11, 'h12, 'h13, 'h14);
        vecs[1].row[2] = mkrow('h21, 'h22, 'h23, 'h24);
        vecs[1].row[3] = mkrow('h31, 'h32, 'h33, 'h34);
        vecs[1].map    = m4(2, 0, 1, 3);
        vecs[1].succ   = 1'b1;
        vecs[1].unm    = 3'd0;
        // One faulty row, dense weights: last row falls back.
        vecs[2].flt    = f4('b0001, 0, 0, 0);
        vecs[2].row[0] = mkrow('h41, 'h42, 'h43, 'h44);
        vecs[2].row[1] = mkrow('h51, 'h52, 'h53, 'h54);
        vecs[2].row[2] = mkrow('h61, 'h62, 'h63, 'h64);
        vecs[2].row[3] = mkrow('h71, 'h72, 'h73, 'h74);
        vecs[2].map    = m4(1, 2, 3, 0);
        vecs[2].succ   = 1'b0;
        vecs[2].unm    = 3'd1;
        // Three faulty rows, dense weights: three fallbacks.
        vecs[3].flt    = f4('b0001, 'b0010, 'b0100, 0);
        vecs[3].row[0] = mkrow('h81, 'h82, 'h83, 'h84);
        vecs[3].row[1] = mkrow('h91, 'h92, 'h93, 'h94);
        vecs[3].row[2] = mkrow('ha1, 'ha2, 'ha3, 'ha4);
        vecs[3].row[3] = mkrow('hb1, 'hb2, 'hb3, 'hb4);
        vecs[3].map    = m4(3, 0, 1, 2);
        vecs[3].succ   = 1'b0;
        vecs[3].unm    = 3'd3;
        // Two compatible faulty rows: lowest index first, clean rows held back.
        vecs[4].flt    = f4(0, 'b0001, 0, 'b0001);
        vecs[4].row[0] = mkrow(0, 5, 5, 5);
        vecs[4].row[1] = mkrow(0, 6, 6, 6);
        vecs[4].row[2] = mkrow(7, 7, 7, 7);
        vecs[4].row[3] = mkrow(8, 8, 8, 8);
        vecs[4].map    = m4(1, 3, 0, 2);
        vecs[4].succ   = 1'b1;
        vecs[4].unm    = 3'd0;

        rst_n = 1'b0; fault_wr_en = 1'b0; fault_wr_addr = '0; fault_wr_pattern = '0;
        cfg_start = 1'b0; w_valid = 1'b0; w_data = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(recovery_done), 64'd0);
        check("rst_success", 64'(recovery_success), 64'd0);
        check("rst_unmapped", 64'(unmapped_count), 64'd0);
        check("rst_w_ready", 64'(w_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_rd_mapped", 64'(rd_mapped_addr), 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            write_faults(vecs[v].flt);
            start_pass();
            feed(vecs[v].row);
            check("success", 64'(recovery_success), 64'(vecs[v].succ));
            check("unmapped_count", 64'(unmapped_count), 64'(vecs[v].unm));
            read_all(vecs[v].map, vecs[v].row);
        end

        // Reset after two accepted rows; fault table from the last vector must be wiped.
        start_pass();
        @(negedge clk); w_valid = 1'b1; w_data = mkrow('hc1, 'hc2, 'hc3, 'hc4);
        @(negedge clk); w_data = mkrow('hd1, 'hd2, 'hd3, 'hd4);
        @(negedge clk); w_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(recovery_done), 64'd0);
        check("midrst_unmapped", 64'(unmapped_count), 64'd0);
        check("midrst_rd_mapped", 64'(rd_mapped_addr), 64'd0);
        check("midrst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rows_a[0] = mkrow('he1, 'he2, 'he3, 'he4);
        rows_a[1] = mkrow('hf1, 'hf2, 'hf3, 'hf4);
        rows_a[2] = mkrow('h15, 'h25, 'h35, 'h45);
        rows_a[3] = mkrow('h16, 'h26, 'h36, 'h46);
        start_pass();
        feed(rows_a);
        check("postrst_success", 64'(recovery_success), 64'd1);
        check("postrst_unmapped", 64'(unmapped_count), 64'd0);
        read_all(m4(0, 1, 2, 3), rows_a);

        // LOAD ignores fault writes and reads; stall, then restart with a colliding row.
        start_pass();
        @(negedge clk);
        fault_wr_en = 1'b1; fault_wr_addr = 2'd0; fault_wr_pattern = 4'b1111;
        rd_en = 1'b1; rd_addr = 2'd1;
        @(negedge clk);
        fault_wr_en = 1'b0; rd_en = 1'b0;
        check("load_rd_valid", 64'(rd_valid), 64'd0);
        check("load_rd_data_hold", 64'(rd_data), 64'(rows_a[3]));
        check("load_rd_mapped_hold", 64'(rd_mapped_addr), 64'd3);
        @(negedge clk); w_valid = 1'b1; w_data = mkrow('haa, 'hab, 'hac, 'had);
        @(negedge clk); w_valid = 1'b0;
        #1 check("stall_w_ready", 64'(w_ready), 64'd1);
        @(negedge clk);
        @(negedge clk); w_valid = 1'b1; w_data = mkrow('hba, 'hbb, 'hbc, 'hbd);
        @(negedge clk); w_data = mkrow('hde, 'had, 'hbe, 'hef); cfg_start = 1'b1;
        #1 check("restart_w_ready", 64'(w_ready), 64'd0);
        @(negedge clk); cfg_start = 1'b0; w_valid = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_done", 64'(recovery_done), 64'd0);
        rows_b[0] = mkrow('h17, 'h27, 'h37, 'h47);
        rows_b[1] = mkrow('h18, 'h28, 'h38, 'h48);
        rows_b[2] = mkrow('h19, 'h29, 'h39, 'h49);
        rows_b[3] = mkrow('h1a, 'h2a, 'h3a, 'h4a);
        feed(rows_b);
        check("restart_success", 64'(recovery_success), 64'd1);
        check("restart_unmapped", 64'(unmapped_count), 64'd0);
        read_all(m4(0, 1, 2, 3), rows_b);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
